// File: rtl/gate_sweep_pkg.sv
// -----------------------------------------------------------------------------
// gate_sweep_pkg
// Shared types and constants for the gate sweep controller: FSM state
// encoding, vector index and hold-counter widths, and a helper that turns a
// hold length into the counter reload value.
// Optional feature macro used elsewhere in this slice: GATE_SWEEP_CHECK_EN.
// -----------------------------------------------------------------------------
package gate_sweep_pkg;

    localparam int NUM_VECTORS = 4;   // input combinations 00,01,10,11
    localparam int IDX_W       = 2;   // width of the vector index / {a,b}
    localparam int CNT_W       = 8;   // hold counter width (HOLD_CYCLES 1..255)

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [CNT_W-1:0] cnt_t;

    // The counter counts down to zero, so a hold of N cycles reloads N-1.
    function automatic cnt_t hold_reload(input int hold_cycles);
        return cnt_t'(hold_cycles - 1);
    endfunction

endpackage

// File: rtl/gate_sweep_if.sv
// -----------------------------------------------------------------------------
// gate_sweep_if
// Bundles the sweep handshake (start/busy/done/truth) and the gate-facing
// signals (a/b out to the gate, y back from it).
//   slave  : the controller side (gate_sweep_ctrl)
//   master : the requester side that issues start and hosts the gate
// With GATE_SWEEP_CHECK_EN defined, expected/mismatch are added.
// -----------------------------------------------------------------------------
interface gate_sweep_if;
    import gate_sweep_pkg::*;

    logic                   start;
    logic                   y;
    logic                   a;
    logic                   b;
    logic                   busy;
    logic                   done;
    logic [NUM_VECTORS-1:0] truth;
`ifdef GATE_SWEEP_CHECK_EN
    logic [NUM_VECTORS-1:0] expected;
    logic [NUM_VECTORS-1:0] mismatch;
`endif

    modport slave (
        input  start,
        input  y,
        output a,
        output b,
        output busy,
        output done,
        output truth
`ifdef GATE_SWEEP_CHECK_EN
        ,
        input  expected,
        output mismatch
`endif
    );

    modport master (
        output start,
        output y,
        input  a,
        input  b,
        input  busy,
        input  done,
        input  truth
`ifdef GATE_SWEEP_CHECK_EN
        ,
        output expected,
        input  mismatch
`endif
    );

endinterface

// File: rtl/gate_sweep_hold_counter.sv
// -----------------------------------------------------------------------------
// hold_counter
// Loadable down-counter that times how long each input combination is held.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load load_val (takes priority over en)
//   load_val   : reload value
//   en         : decrement by one; saturates at zero
//   zero       : count is zero (last cycle of the current hold)
// -----------------------------------------------------------------------------
module hold_counter
    import gate_sweep_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  cnt_t load_val,
    input  logic en,
    output logic zero
);

    cnt_t count;

    // NOTE: every state register gets an explicit reset value and is written
    // with non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/gate_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// gate_sweep_ctrl
// Stimulus-and-capture stage around a two-input combinational gate. On start
// it presents {a,b} = 00,01,10,11, each for HOLD_CYCLES cycles, samples y on
// the last edge of each hold into truth[{a,b}], then pulses done for one cycle.
// Parameters:
//   HOLD_CYCLES : cycles per combination, 1..255 (default 10)
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus (slave) : start, y in; a, b, busy, done, truth out
//                 plus expected in / mismatch out when GATE_SWEEP_CHECK_EN
//                 is defined (mismatch = truth ^ expected, registered with done)
// -----------------------------------------------------------------------------
module gate_sweep_ctrl
    import gate_sweep_pkg::*;
#(
    parameter int HOLD_CYCLES = 10
)
(
    input  logic        clk,
    input  logic        rst_n,
    gate_sweep_if.slave bus
);

    localparam cnt_t RELOAD   = hold_reload(HOLD_CYCLES);
    localparam idx_t LAST_IDX = idx_t'(NUM_VECTORS - 1);

    state_t                 state;
    state_t                 state_next;
    idx_t                   idx;
    idx_t                   ab;
    logic [NUM_VECTORS-1:0] truth_q;
    logic [NUM_VECTORS-1:0] truth_capt;

    logic accept;      // start taken in IDLE
    logic capture;     // last cycle of a hold: sample y this edge
    logic last_vec;    // current vector is the final one
    logic cnt_load;
    logic cnt_en;
    logic cnt_zero;
    logic busy_c;
    logic done_c;

    hold_counter u_hold_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (RELOAD),
        .en       (cnt_en),
        .zero     (cnt_zero)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    assign last_vec = (idx == LAST_IDX);

    // Next-state and control decode.
    always_comb begin
        // NOTE: every output of this block is defaulted first so no path
        // leaves a signal unassigned and no latch is inferred.
        state_next = state;
        accept     = 1'b0;
        capture    = 1'b0;
        cnt_load   = 1'b0;
        cnt_en     = 1'b0;
        busy_c     = 1'b0;
        done_c     = 1'b0;

        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    cnt_load   = 1'b1;
                    state_next = DRIVE;
                end
            end
            DRIVE: begin
                busy_c = 1'b1;
                if (cnt_zero) begin
                    capture = 1'b1;
                    if (last_vec) begin
                        state_next = DONE;
                    end else begin
                        cnt_load = 1'b1;
                    end
                end else begin
                    cnt_en = 1'b1;
                end
            end
            DONE: begin
                busy_c     = 1'b1;
                done_c     = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // truth with the current sample merged in; shared by the truth register
    // and the mismatch compare so the final bit is included the same cycle.
    always_comb begin
        truth_capt      = truth_q;
        truth_capt[idx] = bus.y;
    end

    // Index, gate drive and truth capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx     <= '0;
            ab      <= '0;
            truth_q <= '0;
        end else if (accept) begin
            idx     <= '0;
            ab      <= '0;
            truth_q <= '0;
        end else if (capture) begin
            truth_q <= truth_capt;
            if (last_vec) begin
                // Park the gate inputs at 00 while done is shown.
                ab <= '0;
            end else begin
                idx <= idx + 1'b1;
                ab  <= idx + 1'b1;
            end
        end
    end

    assign bus.a     = ab[1];
    assign bus.b     = ab[0];
    assign bus.busy  = busy_c;
    assign bus.done  = done_c;
    assign bus.truth = truth_q;

`ifdef GATE_SWEEP_CHECK_EN
    logic [NUM_VECTORS-1:0] mismatch_q;

    // Updated on the edge that enters DONE so it is valid alongside done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mismatch_q <= '0;
        end else if (accept) begin
            mismatch_q <= '0;
        end else if (capture && last_vec) begin
            mismatch_q <= truth_capt ^ bus.expected;
        end
    end

    assign bus.mismatch = mismatch_q;
`endif

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// tb_gate_sweep_ctrl
// Three controllers (HOLD_CYCLES = 2, 10, 1) each wrapped around a bench gate
// model selectable as AND / XOR / OR. Every sweep pushes its expected truth
// table, done cycle and mismatch onto a scoreboard when start is driven; the
// entry is popped and compared when the controller raises done.
// Cycle k of a sweep is the state seen after the k-th rising edge following
// the edge at which start was driven; start is first sampled at edge 1.
// -----------------------------------------------------------------------------
module tb_gate_sweep_ctrl;
    import gate_sweep_pkg::*;

    localparam int G_AND = 0;
    localparam int G_XOR = 1;
    localparam int G_OR  = 2;

    typedef struct {
        int         inst;
        logic [3:0] truth;
        int         done_at;
        logic [3:0] mism;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] start_v;
    logic [3:0] exp_v;
    int         gate_sel;
    exp_t       sb[$];
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    function automatic logic gate_fn(input int sel, input logic a, input logic b);
        case (sel)
            G_AND:   return a & b;
            G_XOR:   return a ^ b;
            default: return a | b;
        endcase
    endfunction

    function automatic logic [3:0] truth_of(input int sel);
        logic [3:0] t;
        logic [1:0] v;
        for (int i = 0; i < 4; i++) begin
            v    = 2'(i);
            t[i] = gate_fn(sel, v[1], v[0]);
        end
        return t;
    endfunction

    function automatic int hold_of(input int inst);
        case (inst)
            0:       return 2;
            1:       return 10;
            default: return 1;
        endcase
    endfunction

    gate_sweep_if if0 ();
    gate_sweep_if if1 ();
    gate_sweep_if if2 ();

    assign if0.start = start_v[0];
    assign if1.start = start_v[1];
    assign if2.start = start_v[2];
    assign if0.y     = gate_fn(gate_sel, if0.a, if0.b);
    assign if1.y     = gate_fn(gate_sel, if1.a, if1.b);
    assign if2.y     = gate_fn(gate_sel, if2.a, if2.b);
`ifdef GATE_SWEEP_CHECK_EN
    assign if0.expected = exp_v;
    assign if1.expected = exp_v;
    assign if2.expected = exp_v;
`endif

    gate_sweep_ctrl #(.HOLD_CYCLES(2))  u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    gate_sweep_ctrl #(.HOLD_CYCLES(10)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    gate_sweep_ctrl #(.HOLD_CYCLES(1))  u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    wire [2:0] a_w    = {if2.a, if1.a, if0.a};
    wire [2:0] b_w    = {if2.b, if1.b, if0.b};
    wire [2:0] busy_w = {if2.busy, if1.busy, if0.busy};
    wire [2:0] done_w = {if2.done, if1.done, if0.done};
    logic [3:0] truth_w [3];
    assign truth_w[0] = if0.truth;
    assign truth_w[1] = if1.truth;
    assign truth_w[2] = if2.truth;
`ifdef GATE_SWEEP_CHECK_EN
    logic [3:0] mism_w [3];
    assign mism_w[0] = if0.mismatch;
    assign mism_w[1] = if1.mismatch;
    assign mism_w[2] = if2.mismatch;
`endif

    // Advance one edge and land mid-cycle for sampling / driving.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Drive start (called mid-cycle) and record what the sweep must produce.
    task automatic launch(input int inst, input int sel);
        exp_t e;
        gate_sel       = sel;
        start_v[inst]  = 1'b1;
        e.inst         = inst;
        e.truth        = truth_of(sel);
        e.done_at      = 4 * hold_of(inst) + 1;
        e.mism         = truth_of(sel) ^ exp_v;
        sb.push_back(e);
    endtask

    // Follow the oldest pending sweep until done, checking the drive pattern
    // and draining its scoreboard entry.
    task automatic watch_sweep(input string tag, input bit keep_start);
        exp_t e;
        int   inst;
        int   h;
        int   done_at;
        inst    = sb[0].inst;
        h       = hold_of(inst);
        done_at = -1;
        for (int k = 1; k <= 4 * h + 8; k++) begin
            tick();
            if (k == 1) begin
                if (!keep_start) start_v[inst] = 1'b0;
                checks++;
                if (truth_w[inst] !== 4'b0000) begin
                    errors++;
                    $display("FAIL %s truth_clear: got %b want 0000", tag, truth_w[inst]);
                end
`ifdef GATE_SWEEP_CHECK_EN
                checks++;
                if (mism_w[inst] !== 4'b0000) begin
                    errors++;
                    $display("FAIL %s mismatch_clear: got %b want 0000", tag, mism_w[inst]);
                end
`endif
            end
            if (k <= 4 * h) begin
                checks++;
                if ({a_w[inst], b_w[inst]} !== 2'((k - 1) / h)) begin
                    errors++;
                    $display("FAIL %s ab@%0d: got %b%b want %b", tag, k,
                             a_w[inst], b_w[inst], 2'((k - 1) / h));
                end
                checks++;
                if (busy_w[inst] !== 1'b1) begin
                    errors++;
                    $display("FAIL %s busy@%0d: got %b want 1", tag, k, busy_w[inst]);
                end
            end
            if (done_w[inst] === 1'b1) begin
                done_at = k;
                e = sb.pop_front();
                checks++;
                if (done_at != e.done_at) begin
                    errors++;
                    $display("FAIL %s done_cycle: got %0d want %0d", tag, done_at, e.done_at);
                end
                checks++;
                if (truth_w[inst] !== e.truth) begin
                    errors++;
                    $display("FAIL %s truth: got %b want %b", tag, truth_w[inst], e.truth);
                end
`ifdef GATE_SWEEP_CHECK_EN
                checks++;
                if (mism_w[inst] !== e.mism) begin
                    errors++;
                    $display("FAIL %s mismatch: got %b want %b", tag, mism_w[inst], e.mism);
                end
`endif
                break;
            end
        end
        if (done_at < 0) begin
            checks++;
            errors++;
            $display("FAIL %s done_timeout: got none want cycle %0d", tag, sb[0].done_at);
            e = sb.pop_front();
        end else begin
            tick();
            checks++;
            if ({busy_w[inst], done_w[inst], a_w[inst], b_w[inst]} !== 4'b0000) begin
                errors++;
                $display("FAIL %s after_done busy/done/a/b: got %b%b%b%b want 0000", tag,
                         busy_w[inst], done_w[inst], a_w[inst], b_w[inst]);
            end
            checks++;
            if (truth_w[inst] !== e.truth) begin
                errors++;
                $display("FAIL %s truth_hold: got %b want %b", tag, truth_w[inst], e.truth);
            end
        end
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        start_v = '0;
        exp_v   = '0;
        gate_sel = G_AND;
        repeat (3) tick();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({a_w[i], b_w[i], busy_w[i], done_w[i], truth_w[i]} !== 8'h00) begin
                errors++;
                $display("FAIL reset inst%0d: got %b want 00000000", i,
                         {a_w[i], b_w[i], busy_w[i], done_w[i], truth_w[i]});
            end
        end
        rst_n = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_and_hold2();
        launch(0, G_AND);
        watch_sweep("and_h2", 1'b0);
    endtask

    task automatic test_xor_hold10();
        launch(1, G_XOR);
        watch_sweep("xor_h10", 1'b0);
    endtask

    task automatic test_or_hold1();
        launch(2, G_OR);
        watch_sweep("or_h1", 1'b0);
    endtask

    // start stays high: the second sweep is accepted only once IDLE is back,
    // truth is cleared on re-acceptance, and no further done appears.
    task automatic test_back_to_back();
        int extra;
        launch(0, G_OR);
        watch_sweep("held_first", 1'b1);
        gate_sel = G_AND;
        launch(0, G_AND);
        watch_sweep("held_second", 1'b0);
        extra = 0;
        repeat (12) begin
            tick();
            if (done_w[0] === 1'b1) extra++;
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL held_extra_done: got %0d want 0", extra);
        end
    endtask

    // Reset during the third vector discards the sweep; the next one is clean.
    task automatic test_reset_mid_sweep();
        exp_t e;
        int   stray;
        launch(0, G_OR);
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k == 1) start_v[0] = 1'b0;
        end
        checks++;
        if ({a_w[0], b_w[0], truth_w[0]} !== 6'b10_0010) begin
            errors++;
            $display("FAIL mid_partial ab/truth: got %b want 100010", {a_w[0], b_w[0], truth_w[0]});
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({a_w[0], b_w[0], busy_w[0], done_w[0], truth_w[0]} !== 8'h00) begin
            errors++;
            $display("FAIL mid_reset outputs: got %b want 00000000",
                     {a_w[0], b_w[0], busy_w[0], done_w[0], truth_w[0]});
        end
        e = sb.pop_back();
        stray = 0;
        repeat (2) begin
            tick();
            if (done_w[0] === 1'b1) stray++;
        end
        rst_n = 1'b1;
        repeat (12) begin
            tick();
            if (done_w[0] === 1'b1 || busy_w[0] === 1'b1) stray++;
        end
        checks++;
        if (stray != 0) begin
            errors++;
            $display("FAIL mid_no_done: got %0d busy/done cycles want 0", stray);
        end
        launch(0, G_AND);
        watch_sweep("after_reset", 1'b0);
    endtask

`ifdef GATE_SWEEP_CHECK_EN
    task automatic test_mismatch();
        exp_v = 4'b1001;
        launch(0, G_AND);
        checks++;
        if (sb[sb.size() - 1].mism !== 4'b0001) begin
            errors++;
            $display("FAIL mismatch_model: got %b want 0001", sb[sb.size() - 1].mism);
        end
        watch_sweep("mismatch_and", 1'b0);
        exp_v = 4'b0000;
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_and_hold2();
        test_xor_hold10();
        test_or_hold1();
        test_back_to_back();
        test_reset_mid_sweep();
`ifdef GATE_SWEEP_CHECK_EN
        test_mismatch();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
